radar_statistics_unit: RTL and testbench
========================================

Name: radar_statistics_unit

Overview:
Measures radar antenna timing statistics from three asynchronous radar strobes and a 1 µs timebase, all sampled in the SYS_CLK domain.
- Per antenna revolution (ARP to ARP) it reports the period in microseconds, the ACP count and the TRIG count.
- Sits between the radar input pins and the register/AXI block; software uses the results to scale simulated azimuth and range.
- CALIBRATED marks when the results are valid.

Parameters:
DATA_WIDTH, 32, width of every counter and result output.
SYNC_STAGES, 2, flip-flop stages in each input synchronizer (minimum 2).

Ports:
SYS_CLK  input  1  system clock; all logic is on its rising edge.
RESETN  input  1  reset, synchronous and active-low.
ARP  input  1  azimuth reference pulse, once per revolution; asynchronous.
ACP  input  1  azimuth change pulse; asynchronous.
TRIG  input  1  radar trigger, once per range sweep; asynchronous.
US_CLK  input  1  1 µs timebase; each rising edge is one tick; asynchronous.
CALIBRATED  output  1  high once at least one full ARP period has been measured.
ARP_US  output  DATA_WIDTH  US_CLK ticks in the last complete ARP period.
ACP_CNT  output  DATA_WIDTH  ACP rising edges in the last complete ARP period.
TRIG_CNT  output  DATA_WIDTH  TRIG rising edges in the last complete ARP period.

Behaviour:
- Input conditioning: ARP, ACP, TRIG and US_CLK each pass through a SYNC_STAGES-flop synchronizer, then a one-flop rising-edge detector.
  - Each produces a one-cycle pulse.
  - With the default setting, the pulse is asserted on the 3rd SYS_CLK edge after the input rises. Falling edges are ignored.
- Running counters: us_run, acp_run and trig_run, each DATA_WIDTH bits.
  - Each increments on its own pulse.
  - Each saturates at all-ones; no wrap-around.
- On an ARP pulse:
  - If the armed flag is set, load ARP_US, ACP_CNT and TRIG_CNT from the running counters (including any pulse in that same cycle? no: see next bullet), and set CALIBRATED.
  - Then restart the running counters and set the armed flag.
- Simultaneous events: a US/ACP/TRIG pulse in the same cycle as an ARP pulse belongs to the new period.
  - That counter restarts at 1 instead of 0.
  - The outputs get the old count, excluding that pulse.
- First ARP after reset only arms the unit: no output update, CALIBRATED stays 0.
- Outputs hold their values between ARP pulses. Update latency is 1 cycle after the ARP pulse, i.e. 4 SYS_CLK edges after the ARP input rises.
- Reset (RESETN=0 at a SYS_CLK edge):
  - All synchronizers, counters, outputs and the armed flag go to 0; CALIBRATED=0.
  - Reset mid-period discards the partial measurement; calibration restarts from scratch.
- Inputs with no edges: counters saturate and outputs keep their last values; CALIBRATED never drops except on reset.
- Pulses shorter than one SYS_CLK period may be missed; callers guarantee high and low times of at least 2 SYS_CLK cycles.

Decomposition:
- Shared package: DATA_WIDTH default, SYNC_STAGES default, and a saturating-increment function.
- Natural sub-module: sync_edge_detect (SYNC_STAGES synchronizer plus rising-edge pulse), instantiated four times.
- Stimulus uses the existing clk_divider bench helper.

Test Plan:
- Nominal: SYS_CLK period 10 ns. Drive clk_divider outputs with period in SYS_CLK cycles US=100, TRIG=500, ACP=2500, ARP=12500.
  - After the 2nd ARP edge: CALIBRATED=1, ARP_US=125, ACP_CNT=5, TRIG_CNT=25.
  - The values stay stable over the next 5 periods.
- Reset: RESETN low for 3 cycles mid-period.
  - All outputs 0 on the next edge and CALIBRATED=0.
  - Only the 2nd ARP after release reasserts CALIBRATED with 125/5/25.
- Coincident edges: ACP and ARP rise in the same SYS_CLK cycle, periodically.
  - ACP_CNT reports 5, not 4 or 6; the coincident ACP counts in the new period.
- Period change: ARP period switches from 12500 to 25000 cycles.
  - The 1st update after the switch is 250/10/50; earlier values are held until that update.
- Saturation: DATA_WIDTH=8, US period 100 cycles, ARP period 40000 cycles.
  - ARP_US=255 (saturated), with no wrap to small values.
- No ARP: toggle ACP/TRIG/US without ARP.
  - CALIBRATED stays 0 and outputs stay 0 indefinitely.

Source files
------------

// File: rtl/radar_statistics_unit_pkg.sv
// Shared defaults and helpers for the radar statistics unit.
package radar_statistics_unit_pkg;

  localparam int DATA_WIDTH_DEFAULT  = 32;
  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int SAT_WIDTH           = 64;

  // Saturating increment for any counter width up to SAT_WIDTH bits.
  function automatic logic [SAT_WIDTH-1:0] sat_inc(input logic [SAT_WIDTH-1:0] value,
                                                   input int width);
    logic [SAT_WIDTH-1:0] max_value;
    logic [SAT_WIDTH-1:0] result;
    if (width >= SAT_WIDTH) begin
      max_value = '1;
    end else begin
      max_value = (SAT_WIDTH'(1) << width) - SAT_WIDTH'(1);
    end
    if (value >= max_value) begin
      result = max_value;
    end else begin
      result = value + SAT_WIDTH'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/radar_statistics_unit_sync_edge_detect.sv
// Multi-flop synchronizer followed by a registered rising-edge detector.
module radar_statistics_unit_sync_edge_detect
  import radar_statistics_unit_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;

  // With two stages the pulse register goes high on the 3rd edge after the input rises.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], strobe};
      level_q <= sync_q[SYNC_STAGES-1];
      pulse   <= sync_q[SYNC_STAGES-1] & ~level_q;
    end
  end

endmodule

// File: rtl/radar_statistics_unit.sv
// Measures ARP period (in 1 us ticks), ACP count and TRIG count per antenna revolution.
module radar_statistics_unit
  import radar_statistics_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic                  SYS_CLK,
  input  logic                  RESETN,
  input  logic                  ARP,
  input  logic                  ACP,
  input  logic                  TRIG,
  input  logic                  US_CLK,
  output logic                  CALIBRATED,
  output logic [DATA_WIDTH-1:0] ARP_US,
  output logic [DATA_WIDTH-1:0] ACP_CNT,
  output logic [DATA_WIDTH-1:0] TRIG_CNT
);

  logic                  arp_pulse;
  logic                  acp_pulse;
  logic                  trig_pulse;
  logic                  us_pulse;
  logic [DATA_WIDTH-1:0] us_run;
  logic [DATA_WIDTH-1:0] acp_run;
  logic [DATA_WIDTH-1:0] trig_run;
  logic                  armed;

  function automatic logic [DATA_WIDTH-1:0] bump(input logic [DATA_WIDTH-1:0] value);
    return DATA_WIDTH'(sat_inc(SAT_WIDTH'(value), DATA_WIDTH));
  endfunction

  radar_statistics_unit_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_arp_sync (
    .clk(SYS_CLK), .rst_n(RESETN), .strobe(ARP), .pulse(arp_pulse)
  );
  radar_statistics_unit_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_acp_sync (
    .clk(SYS_CLK), .rst_n(RESETN), .strobe(ACP), .pulse(acp_pulse)
  );
  radar_statistics_unit_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_trig_sync (
    .clk(SYS_CLK), .rst_n(RESETN), .strobe(TRIG), .pulse(trig_pulse)
  );
  radar_statistics_unit_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_us_sync (
    .clk(SYS_CLK), .rst_n(RESETN), .strobe(US_CLK), .pulse(us_pulse)
  );

  always_ff @(posedge SYS_CLK) begin
    if (!RESETN) begin
      us_run     <= '0;
      acp_run    <= '0;
      trig_run   <= '0;
      armed      <= 1'b0;
      CALIBRATED <= 1'b0;
      ARP_US     <= '0;
      ACP_CNT    <= '0;
      TRIG_CNT   <= '0;
    end else if (arp_pulse) begin
      if (armed) begin
        ARP_US     <= us_run;
        ACP_CNT    <= acp_run;
        TRIG_CNT   <= trig_run;
        CALIBRATED <= 1'b1;
      end
      // A pulse coincident with ARP opens the new period rather than closing the old one.
      us_run   <= DATA_WIDTH'(us_pulse);
      acp_run  <= DATA_WIDTH'(acp_pulse);
      trig_run <= DATA_WIDTH'(trig_pulse);
      armed    <= 1'b1;
    end else begin
      if (us_pulse)   us_run   <= bump(us_run);
      if (acp_pulse)  acp_run  <= bump(acp_run);
      if (trig_pulse) trig_run <= bump(trig_run);
    end
  end

endmodule

// File: tb/tb_radar_statistics_unit.sv
// Bench for radar_statistics_unit: a 32-bit and an 8-bit instance share one stimulus stream.
module tb_radar_statistics_unit;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        resetn;
  logic        arp, acp, trig, us_clk;
  logic        cal_w, cal_n;
  logic [31:0] arp_us_w, acp_cnt_w, trig_cnt_w;
  logic [7:0]  arp_us_n, acp_cnt_n, trig_cnt_n;

  radar_statistics_unit #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut_wide (
    .SYS_CLK(sys_clk), .RESETN(resetn), .ARP(arp), .ACP(acp), .TRIG(trig), .US_CLK(us_clk),
    .CALIBRATED(cal_w), .ARP_US(arp_us_w), .ACP_CNT(acp_cnt_w), .TRIG_CNT(trig_cnt_w)
  );

  radar_statistics_unit #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut_narrow (
    .SYS_CLK(sys_clk), .RESETN(resetn), .ARP(arp), .ACP(acp), .TRIG(trig), .US_CLK(us_clk),
    .CALIBRATED(cal_n), .ARP_US(arp_us_n), .ACP_CNT(acp_cnt_n), .TRIG_CNT(trig_cnt_n)
  );

  typedef struct {
    bit          cal;
    int unsigned us;
    int unsigned acp;
    int unsigned trig;
  } snap_t;

  // Expected outputs per sampled edge; an input rise sampled at edge k shows at edge k+3.
  snap_t       hist[$];
  int          checks   = 0;
  int          failures = 0;

  // Square-wave generators: index 0 ARP, 1 ACP, 2 TRIG, 3 US_CLK.
  longint      per[4];
  longint      off[4];
  bit          arp_en;
  longint      t;
  int          rst_left;

  // Reference model: event timestamps per strobe, counted between ARP rises.
  logic [3:0]  prev_lv;
  bit          armed;
  bit          m_cal;
  int unsigned m_us, m_acp, m_trig;
  longint      ev_acp[$];
  longint      ev_trig[$];
  longint      ev_us[$];

  task automatic check_val(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0d", tag, actual, expected, t);
    end
  endtask

  function automatic int unsigned sat8(input int unsigned v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic logic gen_level(input int idx);
    if (idx == 0 && !arp_en) return 1'b0;
    return ((t + off[idx]) % per[idx]) < (per[idx] / 2);
  endfunction

  task automatic model_reset();
    prev_lv = '0;
    armed   = 1'b0;
    m_cal   = 1'b0;
    m_us    = 0;
    m_acp   = 0;
    m_trig  = 0;
    ev_acp.delete();
    ev_trig.delete();
    ev_us.delete();
    hist.delete();
    repeat (3) hist.push_back('{1'b0, 0, 0, 0});
  endtask

  task automatic model_edge(input logic [3:0] lv);
    logic [3:0] rise;
    rise    = lv & ~prev_lv;
    prev_lv = lv;
    if (rise[1]) ev_acp.push_back(t);
    if (rise[2]) ev_trig.push_back(t);
    if (rise[3]) ev_us.push_back(t);
    if (rise[0]) begin
      if (armed) begin
        m_acp  = 0;
        m_trig = 0;
        m_us   = 0;
        foreach (ev_acp[j])  if (ev_acp[j]  < t) m_acp++;
        foreach (ev_trig[j]) if (ev_trig[j] < t) m_trig++;
        foreach (ev_us[j])   if (ev_us[j]   < t) m_us++;
        m_cal = 1'b1;
      end
      while (ev_acp.size()  > 0 && ev_acp[0]  < t) ev_acp.delete(0);
      while (ev_trig.size() > 0 && ev_trig[0] < t) ev_trig.delete(0);
      while (ev_us.size()   > 0 && ev_us[0]   < t) ev_us.delete(0);
      armed = 1'b1;
    end
  endtask

  task automatic compare_hist();
    snap_t e;
    e = hist.pop_front();
    check_val("cal_w",      64'(cal_w),      64'(e.cal));
    check_val("arp_us_w",   64'(arp_us_w),   64'(e.us));
    check_val("acp_cnt_w",  64'(acp_cnt_w),  64'(e.acp));
    check_val("trig_cnt_w", 64'(trig_cnt_w), 64'(e.trig));
    check_val("cal_n",      64'(cal_n),      64'(e.cal));
    check_val("arp_us_n",   64'(arp_us_n),   64'(sat8(e.us)));
    check_val("acp_cnt_n",  64'(acp_cnt_n),  64'(sat8(e.acp)));
    check_val("trig_cnt_n", 64'(trig_cnt_n), 64'(sat8(e.trig)));
  endtask

  // Each iteration: check outputs at the falling edge, then drive inputs for the next rising edge.
  task automatic run_cycles(input int n);
    logic [3:0] lv;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      compare_hist();
      if (rst_left > 0) begin
        resetn = 1'b0;
        lv     = '0;
        rst_left--;
        model_reset();
      end else begin
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) lv[k] = gen_level(k);
        model_edge(lv);
      end
      arp    = lv[0];
      acp    = lv[1];
      trig   = lv[2];
      us_clk = lv[3];
      hist.push_back('{m_cal, m_us, m_acp, m_trig});
      t++;
    end
  endtask

  task automatic check_outputs(input string tag, input bit cal, input int unsigned us,
                               input int unsigned acp_c, input int unsigned trig_c);
    check_val({tag, "_cal_w"},  64'(cal_w),      64'(cal));
    check_val({tag, "_us_w"},   64'(arp_us_w),   64'(us));
    check_val({tag, "_acp_w"},  64'(acp_cnt_w),  64'(acp_c));
    check_val({tag, "_trig_w"}, 64'(trig_cnt_w), 64'(trig_c));
    check_val({tag, "_cal_n"},  64'(cal_n),      64'(cal));
  endtask

  initial begin
    resetn = 1'b0;
    arp = 1'b0; acp = 1'b0; trig = 1'b0; us_clk = 1'b0;
    prev_lv = '0; armed = 1'b0; m_cal = 1'b0; m_us = 0; m_acp = 0; m_trig = 0;
    rst_left = 0;
    repeat (4) hist.push_back('{1'b0, 0, 0, 0});
    repeat (3) @(negedge sys_clk);
    check_outputs("reset", 1'b0, 0, 0, 0);

    // No ARP: strobes toggle, nothing may be reported.
    per = '{12500, 2500, 500, 100};
    off = '{0, 0, 0, 0};
    arp_en = 1'b0;
    t = 0;
    run_cycles(3000);
    check_outputs("no_arp", 1'b0, 0, 0, 0);

    // Nominal: reset so that every strobe rises at the release edge t=0.
    rst_left = 3;
    t = -3;
    arp_en = 1'b1;
    run_cycles(3 + 12504);
    check_outputs("nom_pre", 1'b0, 0, 0, 0);
    run_cycles(1);
    check_outputs("nom", 1'b1, 125, 5, 25);
    check_val("nom_us_n", 64'(arp_us_n), 64'd125);

    // Reset mid-period while ARP is low; only the 2nd ARP afterwards recalibrates.
    run_cycles(int'(20000 - t));
    rst_left = 3;
    run_cycles(2);
    check_outputs("rst_mid", 1'b0, 0, 0, 0);
    run_cycles(int'(37503 - t + 1));
    check_outputs("rst_pre", 1'b0, 0, 0, 0);
    run_cycles(1);
    check_outputs("rst_recal", 1'b1, 125, 5, 25);

    // Period change to 25000 cycles, continuous with the ARP rise at t=37500.
    per[0] = 25000;
    off[0] = 12500;
    run_cycles(int'(62503 - t + 1));
    check_outputs("chg_hold", 1'b1, 125, 5, 25);
    run_cycles(1);
    check_outputs("chg", 1'b1, 250, 10, 50);

    // Random periods/phases; fast US drives the 8-bit ARP_US into saturation.
    for (int r = 0; r < 2; r++) begin
      rst_left = 3;
      per[0] = 4 * longint'($urandom_range(275, 350));
      per[1] = longint'($urandom_range(6, 40));
      per[2] = longint'($urandom_range(4, 30));
      per[3] = 4;
      for (int k = 0; k < 4; k++) off[k] = longint'($urandom_range(0, 1000)) % per[k];
      run_cycles(5000);
      check_val("sat_cal_n",    64'(cal_n),    64'd1);
      check_val("sat_arp_us_n", 64'(arp_us_n), 64'd255);
      check_val("sat_arp_us_w", 64'(arp_us_w), 64'(per[0] / 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
